// File: rtl/grace_arb.sv
// rtl/grace_arb.sv - round-robin arbiter onto the Grace slave bus.
// Define GRACE_ARB_TIMEOUT_EN to add the ack-timeout counter (limit TO) in WAIT.
module grace_arb #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int WW = 1,
  parameter int AW = 8,
  parameter int TO = 15
) (
  input  logic               Grace_Ck,
  input  logic               Grace_Rs_N,
  input  logic               Grace_CE,
  input  logic [NR-1:0]      Req_Vld,
  input  logic [NR*WW-1:0]   Req_WR,
  input  logic [NR*AW-1:0]   Req_Ad,
  input  logic [NR*DW-1:0]   Req_WD,
  output logic [NR-1:0]      Req_Gnt,
  output logic [NR-1:0]      Rsp_Vld,
  output logic [DW-1:0]      Rsp_RD,
  output logic               Rsp_Err,
  output logic               Grace_CS,
  output logic [WW-1:0]      Grace_WR,
  output logic [AW-1:0]      Grace_Ad,
  output logic [DW-1:0]      Grace_WD,
  input  logic               Grace_Ac,
  input  logic [DW-1:0]      Grace_RD
);

  localparam int PW = $clog2(NR);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cur_idx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] nxt_ptr;
  logic [PW:0]   cand;
  logic [WW-1:0] wr_lat;
  logic [NR-1:0] gnt_q;
  logic [NR-1:0] vld_q;
`ifdef GRACE_ARB_TIMEOUT_EN
  logic [7:0]    to_cnt;
  logic          err_q;
`endif

  // Scan downward from the pointer so the nearest requester at/after rr_ptr wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NR)) cand = cand - (PW+1)'(NR);
      if (Req_Vld[cand[PW-1:0]]) win_idx = cand[PW-1:0];
    end
  end

  assign nxt_ptr = (win_idx == PW'(NR - 1)) ? '0 : win_idx + 1'b1;

  // Pulses are held in their registers until a CE cycle consumes them, and only shown while CE=1.
  assign Req_Gnt = gnt_q & {NR{Grace_CE}};
  assign Rsp_Vld = vld_q & {NR{Grace_CE}};
`ifdef GRACE_ARB_TIMEOUT_EN
  assign Rsp_Err = err_q & Grace_CE;
`else
  assign Rsp_Err = 1'b0;
`endif

  always_ff @(posedge Grace_Ck or negedge Grace_Rs_N) begin
    if (!Grace_Rs_N) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_idx  <= '0;
      wr_lat   <= '0;
      gnt_q    <= '0;
      vld_q    <= '0;
      Rsp_RD   <= '0;
      Grace_CS <= 1'b0;
      Grace_WR <= '0;
      Grace_Ad <= '0;
      Grace_WD <= '0;
`ifdef GRACE_ARB_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else if (Grace_CE) begin
      gnt_q <= '0;
      vld_q <= '0;
`ifdef GRACE_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|Req_Vld) begin
            cur_idx  <= win_idx;
            rr_ptr   <= nxt_ptr;
            gnt_q    <= NR'(1) << win_idx;
            wr_lat   <= Req_WR[int'(win_idx)*WW +: WW];
            Grace_Ad <= Req_Ad[int'(win_idx)*AW +: AW];
            Grace_WD <= Req_WD[int'(win_idx)*DW +: DW];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          Grace_CS <= 1'b1;
          Grace_WR <= wr_lat;
`ifdef GRACE_ARB_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          if (Grace_Ac) begin
            Rsp_RD   <= Grace_RD;
            vld_q    <= NR'(1) << cur_idx;
            Grace_CS <= 1'b0;
            Grace_WR <= '0;
            state    <= DRAIN;
          end
`ifdef GRACE_ARB_TIMEOUT_EN
          else if (to_cnt == 8'(TO - 1)) begin
            vld_q    <= NR'(1) << cur_idx;
            err_q    <= 1'b1;
            Grace_CS <= 1'b0;
            Grace_WR <= '0;
            state    <= DRAIN;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        DRAIN: begin
          if (!Grace_Ac) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
